// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared widths, ALU/CMP codes, immediate kinds and the packed uop layout.
package decode_queue_pkg;
  localparam int WORD = 32;
  localparam int REG_LOG = 5;
  localparam int OPCODE_LEN = 4;
  localparam logic [OPCODE_LEN-1:0] ALU_ADD = 4'd0;
  localparam logic [OPCODE_LEN-1:0] ALU_SUB = 4'd1;
  localparam logic [OPCODE_LEN-1:0] ALU_AND = 4'd2;
  localparam logic [OPCODE_LEN-1:0] ALU_OR = 4'd3;
  localparam logic [OPCODE_LEN-1:0] ALU_XOR = 4'd4;
  localparam logic [OPCODE_LEN-1:0] ALU_SRL = 4'd5;
  localparam logic [OPCODE_LEN-1:0] ALU_SLTU = 4'd6;
  localparam logic [OPCODE_LEN-1:0] CMP_NONE = 4'd0;
  localparam logic [OPCODE_LEN-1:0] CMP_EQ = 4'd1;
  localparam logic [OPCODE_LEN-1:0] CMP_NE = 4'd2;
  localparam logic [OPCODE_LEN-1:0] CMP_GE = 4'd3;
  localparam logic [OPCODE_LEN-1:0] CMP_B = 4'd4;
  typedef enum logic [2:0] {
    IMM_ZERO,
    IMM_SI12,
    IMM_UI12,
    IMM_SI20,
    IMM_OFFS16,
    IMM_OFFS26
  } imm_kind_e;
  typedef struct packed {
    logic [OPCODE_LEN-1:0] alu_op;
    logic [OPCODE_LEN-1:0] cmp_op;
    logic [3*REG_LOG-1:0] rs;
    logic [1:0] reg_wb;
    logic [1:0] mem;
    logic [3:0] ex;
    logic [WORD-1:0] imm;
    logic ill;
  } uop_t;
  localparam int UOP_W = $bits(uop_t);
endpackage

// File: rtl/decode_queue_core.sv
// decode_core: combinational instruction decoder producing one packed uop.
module decode_core
  import decode_queue_pkg::*;
(
  input  logic [WORD-1:0] inst_i,
  output uop_t            uop_o
);
  logic [16:0] op17;
  logic [9:0] op10;
  logic [6:0] op7;
  logic [5:0] op6;
  logic add_w, sub_w, and_w, or_w, xor_w, srl_w, mul_w;
  logic sltui, addi, andi, ori, lu12i, pcaddu12i, ld, st;
  logic jirl, b, bl, beq, bne, bge;
  logic r3, bbl, br, legal;
  imm_kind_e kind;
  assign op17 = inst_i[31:15];
  assign op10 = inst_i[31:22];
  assign op7 = inst_i[31:25];
  assign op6 = inst_i[31:26];
  assign add_w = op17 == 17'h00020;
  assign sub_w = op17 == 17'h00022;
  assign and_w = op17 == 17'h00029;
  assign or_w = op17 == 17'h0002a;
  assign xor_w = op17 == 17'h0002b;
  assign srl_w = op17 == 17'h0002f;
  assign mul_w = op17 == 17'h00038;
  assign sltui = op10 == 10'h009;
  assign addi = op10 == 10'h00a;
  assign andi = op10 == 10'h00d;
  assign ori = op10 == 10'h00e;
  assign lu12i = op7 == 7'h0a;
  assign pcaddu12i = op7 == 7'h0e;
  assign ld = inst_i[31:24] == 8'h28;
  assign st = inst_i[31:24] == 8'h29;
  assign jirl = op6 == 6'h13;
  assign b = op6 == 6'h14;
  assign bl = op6 == 6'h15;
  assign beq = op6 == 6'h16;
  assign bne = op6 == 6'h17;
  assign bge = op6 == 6'h19;
  assign r3 = inst_i[31:20] == 12'h001;
  assign bbl = inst_i[31:27] == 5'b01010;
  assign br = inst_i[31:30] == 2'b01;
  assign legal = add_w | sub_w | and_w | or_w | xor_w | srl_w | mul_w | sltui | addi | andi | ori |
                 lu12i | pcaddu12i | ld | st | jirl | b | bl | beq | bne | bge;
  always_comb begin
    uop_o = '0;
    kind = (sltui | addi | ld | st) ? IMM_SI12 :
           (andi | ori) ? IMM_UI12 :
           (lu12i | pcaddu12i) ? IMM_SI20 :
           (jirl | beq | bne | bge) ? IMM_OFFS16 :
           bbl ? IMM_OFFS26 : IMM_ZERO;
    uop_o.alu_op = sub_w ? ALU_SUB :
                   (and_w | andi) ? ALU_AND :
                   (or_w | ori) ? ALU_OR :
                   xor_w ? ALU_XOR :
                   srl_w ? ALU_SRL :
                   sltui ? ALU_SLTU : ALU_ADD;
    uop_o.cmp_op = beq ? CMP_EQ : bne ? CMP_NE : bge ? CMP_GE : (b | bl | jirl) ? CMP_B : CMP_NONE;
    uop_o.rs = {r3 ? inst_i[14:10] : 5'd0,
                (inst_i[31:28] == 4'b0001 || bbl) ? 5'd0 : inst_i[9:5],
                bbl ? {4'd0, inst_i[26]} : inst_i[4:0]};
    // illegal encodings are neutered so they retire without architectural effect
    uop_o.reg_wb = {legal & (jirl | bl | ~inst_i[30]), inst_i[30:29] == 2'b01};
    uop_o.mem = {legal & ld, legal & st};
    uop_o.ex = {legal & br, mul_w, (inst_i[31:28] == 4'b0001) | br, ~r3};
    uop_o.imm = kind == IMM_SI12 ? WORD'($signed(inst_i[21:10])) :
                kind == IMM_UI12 ? WORD'(inst_i[21:10]) :
                kind == IMM_SI20 ? {inst_i[24:5], 12'd0} :
                kind == IMM_OFFS16 ? WORD'($signed({inst_i[25:10], 2'b00})) :
                kind == IMM_OFFS26 ? WORD'($signed({inst_i[9:0], inst_i[25:10], 2'b00})) : '0;
    uop_o.ill = ~legal;
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions and buffers the uops in a flushable FIFO.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_LOG = 5,
  parameter int OP_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_pc,
  output logic [OP_W-1:0]            out_alu_op,
  output logic [OP_W-1:0]            out_cmp_op,
  output logic [3*REG_LOG-1:0]       out_rs,
  output logic [1:0]                 out_reg_wb,
  output logic [1:0]                 out_mem,
  output logic [3:0]                 out_ex,
  output logic [WORD_W-1:0]          out_imm,
  output logic                       out_ill,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    uop_t uop;
  } entry_t;
  uop_t dec;
  entry_t mem_q [DEPTH];
  entry_t head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  decode_core u_core (
    .inst_i(in_inst),
    .uop_o (dec)
  );
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count = count_q;
  assign head = mem_q[rd_q];
  assign out_pc = head.pc;
  assign out_alu_op = head.uop.alu_op;
  assign out_cmp_op = head.uop.cmp_op;
  assign out_rs = head.uop.rs;
  assign out_reg_wb = head.uop.reg_wb;
  assign out_mem = head.uop.mem;
  assign out_ex = head.uop.ex;
  assign out_imm = head.uop.imm;
  assign out_ill = head.uop.ill;
  always_comb begin
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // entries are cleared on reset so an empty queue presents all-zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      if (push && !flush) mem_q[wr_q] <= {in_pc, dec};
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed stimulus checked against a mnemonic-level queue model.
module tb_decode_queue;
  import decode_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid, out_ill;
  logic [31:0] out_pc, out_imm;
  logic [3:0] out_alu_op, out_cmp_op, out_ex;
  logic [14:0] out_rs;
  logic [1:0] out_reg_wb, out_mem;
  logic [2:0] count;
  always #5 clk = ~clk;
  decode_queue #(.WORD_W(32), .REG_LOG(5), .OP_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_op(out_alu_op), .out_cmp_op(out_cmp_op), .out_rs(out_rs),
    .out_reg_wb(out_reg_wb), .out_mem(out_mem), .out_ex(out_ex), .out_imm(out_imm),
    .out_ill(out_ill), .count(count)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0] alu, cmp;
    logic [14:0] rs;
    logic [1:0] wb, mem;
    logic [3:0] ex;
    logic [31:0] imm;
    logic ill;
  } exp_t;
  exp_t mq[$];
  bit zero_chk;
  int checks, errors;
  logic [16:0] ops17 [7] = '{17'h20, 17'h22, 17'h29, 17'h2a, 17'h2b, 17'h2f, 17'h38};
  logic [9:0] ops10 [6] = '{10'h009, 10'h00a, 10'h00d, 10'h00e, 10'h0a2, 10'h0a6};
  logic [5:0] ops6 [6] = '{6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h19};

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  function automatic exp_t ref_uop(input logic [31:0] pc, input logic [31:0] i);
    exp_t e;
    string m = "ill";
    longint v;
    bit br, ill;
    int unsigned rs2, rs1, rs0;
    case (i >> 15)
      32'h20: m = "add"; 32'h22: m = "sub"; 32'h29: m = "and"; 32'h2a: m = "or";
      32'h2b: m = "xor"; 32'h2f: m = "srl"; 32'h38: m = "mul";
      default: ;
    endcase
    case (i >> 22)
      32'h009: m = "sltui"; 32'h00a: m = "addi"; 32'h00d: m = "andi"; 32'h00e: m = "ori";
      default: ;
    endcase
    case (i >> 25)
      32'h0a: m = "lu12i"; 32'h0e: m = "pcaddu12i";
      default: ;
    endcase
    case (i >> 24)
      32'h28: m = "ld"; 32'h29: m = "st";
      default: ;
    endcase
    case (i >> 26)
      32'h13: m = "jirl"; 32'h14: m = "b"; 32'h15: m = "bl"; 32'h16: m = "beq";
      32'h17: m = "bne"; 32'h19: m = "bge";
      default: ;
    endcase
    ill = m == "ill";
    br = (i >> 30) == 1;
    e.pc = pc;
    e.alu = m == "sub" ? ALU_SUB : (m == "and" || m == "andi") ? ALU_AND :
            (m == "or" || m == "ori") ? ALU_OR : m == "xor" ? ALU_XOR :
            m == "srl" ? ALU_SRL : m == "sltui" ? ALU_SLTU : ALU_ADD;
    e.cmp = m == "beq" ? CMP_EQ : m == "bne" ? CMP_NE : m == "bge" ? CMP_GE :
            (m == "b" || m == "bl" || m == "jirl") ? CMP_B : CMP_NONE;
    rs2 = (i >> 20) == 1 ? (i >> 10) & 31 : 0;
    rs1 = ((i >> 28) == 1 || (i >> 27) == 10) ? 0 : (i >> 5) & 31;
    rs0 = (i >> 27) == 10 ? (i >> 26) & 1 : i & 31;
    e.rs = {5'(rs2), 5'(rs1), 5'(rs0)};
    e.wb = {!ill && (m == "jirl" || m == "bl" || ((i >> 30) & 1) == 0), ((i >> 29) & 3) == 1};
    e.mem = {!ill && (i >> 24) == 32'h28, !ill && (i >> 24) == 32'h29};
    e.ex = {br && !ill, (i >> 15) == 32'h38, (i >> 28) == 1 || br, (i >> 20) != 1};
    if (m == "addi" || m == "sltui" || m == "ld" || m == "st") begin
      v = (i >> 10) & 32'hfff;
      if (v >= 2048) v -= 4096;
    end else if (m == "andi" || m == "ori") v = (i >> 10) & 32'hfff;
    else if (m == "lu12i" || m == "pcaddu12i") v = ((i >> 5) & 32'hfffff) * 4096;
    else if (m == "jirl" || m == "beq" || m == "bne" || m == "bge") begin
      v = (i >> 10) & 32'hffff;
      if (v >= 32768) v -= 65536;
      v *= 4;
    end else if (m == "b" || m == "bl") begin
      v = ((i & 32'h3ff) << 16) | ((i >> 10) & 32'hffff);
      if (v >= (64'd1 << 25)) v -= (64'd1 << 26);
      v *= 4;
    end else v = 0;
    e.imm = 32'(v);
    e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:15] = ops17[$urandom_range(0, 6)];
      1, 2: r[31:22] = ops10[$urandom_range(0, 5)];
      3: r[31:25] = $urandom_range(0, 1) ? 7'h0a : 7'h0e;
      4, 5: r[31:26] = ops6[$urandom_range(0, 5)];
      6: r[31:26] = 6'($urandom_range(16, 27));
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    bit push, pop;
    if (rst) begin
      mq.delete();
      zero_chk = 1;
    end else if (flush) mq.delete();
    else begin
      push = in_valid && mq.size() < DEPTH;
      pop = out_ready && mq.size() > 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(ref_uop(in_pc, in_inst));
        zero_chk = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("count", 64'(count), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("alu_op", 64'(out_alu_op), 64'(mq[0].alu));
      chk("cmp_op", 64'(out_cmp_op), 64'(mq[0].cmp));
      chk("rs", 64'(out_rs), 64'(mq[0].rs));
      chk("reg_wb", 64'(out_reg_wb), 64'(mq[0].wb));
      chk("mem", 64'(out_mem), 64'(mq[0].mem));
      chk("ex", 64'(out_ex), 64'(mq[0].ex));
      chk("imm", 64'(out_imm), 64'(mq[0].imm));
      chk("ill", 64'(out_ill), 64'(mq[0].ill));
    end else if (zero_chk) begin
      chk("idle_pc_imm", {out_pc, out_imm}, 64'd0);
      chk("idle_fields", 64'({out_alu_op, out_cmp_op, out_rs, out_reg_wb, out_mem, out_ex, out_ill}), 64'd0);
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic r);
    in_valid = v;
    in_pc = pc;
    in_inst = inst;
    out_ready = ordy;
    flush = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_pc", 64'(out_pc), 0);
    e = ref_uop(0, 32'h02BFFCA4);
    chk("model_addi_imm", 64'(e.imm), 64'hFFFFFFFF);
    chk("model_addi_rs", 64'(e.rs), 64'({5'd0, 5'd5, 5'd4}));
    step(1, 32'h100, 32'h02BFFCA4, 1, 0, 0);
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_alu", 64'(out_alu_op), 64'(ALU_ADD));
    chk("addi_rs", 64'(out_rs), 64'({5'd0, 5'd5, 5'd4}));
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_wb", 64'(out_reg_wb), 2);
    chk("addi_ex0", 64'(out_ex[0]), 1);
    chk("addi_ill", 64'(out_ill), 0);
    step(0, 0, 0, 1, 0, 0);
    e = ref_uop(0, 32'h54000800);
    chk("model_bl_imm", 64'(e.imm), 8);
    step(1, 32'h104, 32'h54000800, 1, 0, 0);
    chk("bl_rs0", 64'(out_rs[4:0]), 1);
    chk("bl_rs1", 64'(out_rs[9:5]), 0);
    chk("bl_cmp", 64'(out_cmp_op), 64'(CMP_B));
    chk("bl_wb", 64'(out_reg_wb[1]), 1);
    chk("bl_imm", 64'(out_imm), 8);
    chk("bl_branch", 64'(out_ex[3]), 1);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h200 + 4 * i, gen(), 0, 0, 0);
    chk("full_count", 64'(count), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pop_only_count", 64'(count), 3);
    chk("pop_only_pc", 64'(out_pc), 32'h204);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    chk("drained", 64'(out_valid), 0);
    step(1, 32'h400, gen(), 0, 0, 0);
    step(1, 32'h404, gen(), 0, 0, 0);
    step(1, 32'h408, gen(), 1, 0, 0);
    chk("push_pop_count", 64'(count), 2);
    chk("push_pop_pc", 64'(out_pc), 32'h404);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 4 * i, gen(), 0, 0, 0);
    step(1, 32'h50c, gen(), 1, 1, 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(out_valid), 0);
    step(1, 32'h600, 32'hFFFFFFFF, 0, 0, 0);
    chk("ill_flag", 64'(out_ill), 1);
    chk("ill_wb", 64'(out_reg_wb[1]), 0);
    chk("ill_mem", 64'(out_mem), 0);
    step(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, $urandom, gen(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
    step(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
